// File: rtl/seq_divider16.sv
// Iterative restoring divider: one quotient bit per cycle through a start/done handshake.
// Optional signed support is compiled in with `define DIV_SIGNED_EN (adds the signed_op port).
module seq_divider16 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ZERO, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_dvd_orig;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic             w_signed;
  logic             w_accept;
  logic             w_last;
  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_mag_dvd;
  logic [WIDTH-1:0] w_mag_dvs;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_r_step;
  logic [WIDTH-1:0] w_q_step;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

`ifdef DIV_SIGNED_EN
  assign w_signed = signed_op;
`else
  assign w_signed = 1'b0;
`endif

  assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

  // Signed operands are divided as magnitudes; signs are reapplied when results are written.
  assign w_dvd_neg = w_signed & dividend[WIDTH-1];
  assign w_dvs_neg = w_signed & divisor[WIDTH-1];
  assign w_mag_dvd = w_dvd_neg ? ({WIDTH{1'b0}} - dividend) : dividend;
  assign w_mag_dvs = w_dvs_neg ? ({WIDTH{1'b0}} - divisor) : divisor;

  // Trial subtract keeps the shifted-out remainder bit so divisors with the msb set still work.
  assign w_trial   = {r_rem, r_q[WIDTH-1]} - {1'b0, r_div};
  assign w_ge      = ~w_trial[WIDTH];
  assign w_r_step  = w_ge ? w_trial[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_q[WIDTH-1]};
  assign w_q_step  = {r_q[WIDTH-2:0], w_ge};
  assign w_q_fix   = r_neg_q ? ({WIDTH{1'b0}} - w_q_step) : w_q_step;
  assign w_r_fix   = r_neg_r ? ({WIDTH{1'b0}} - w_r_step) : w_r_step;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = (divisor == '0) ? S_ZERO : S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_ZERO: begin
        busy         = 1'b1;
        w_state_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (w_accept) w_state_next = (divisor == '0) ? S_ZERO : S_CALC;
        else          w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_div       <= '0;
      r_dvd_orig  <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else if (w_accept) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_q        <= w_mag_dvd;
      r_div      <= w_mag_dvs;
      r_dvd_orig <= dividend;
      r_neg_q    <= w_dvd_neg ^ w_dvs_neg;
      r_neg_r    <= w_dvd_neg;
      r_dbz      <= 1'b0;
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt + 1'b1;
      r_rem <= w_r_step;
      r_q   <= w_q_step;
      if (w_last) begin
        r_quotient  <= w_q_fix;
        r_remainder <= w_r_fix;
      end
    end else if (r_state == S_ZERO) begin
      r_quotient  <= '1;
      r_remainder <= r_dvd_orig;
      r_dbz       <= 1'b1;
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule
